// File: rtl/crc_sched.sv
// Frame-level scheduler sharing one byte-serial CRC datapath (CRC8/16_1021/16_8005/32) between requesters.
// Define CRC_SCHED_FIXPRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module crc_sched #(
    parameter int REQ_NUM  = 4,
    parameter int ID_WIDTH = $clog2(REQ_NUM)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [REQ_NUM-1:0]      req_valid_i,
    output logic [REQ_NUM-1:0]      req_ready_o,
    input  logic [REQ_NUM*32-1:0]   req_data_i,
    input  logic [REQ_NUM-1:0]      req_last_i,
    input  logic [REQ_NUM*6-1:0]    req_cfg_i,
    input  logic [REQ_NUM*32-1:0]   req_init_i,
    input  logic [REQ_NUM*32-1:0]   req_xorv_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [31:0]             res_data_o,
    output logic [ID_WIDTH-1:0]     res_id_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {IDLE, FETCH, CALC, RESP} state_e;

    localparam logic [1:0] MODE_CRC8  = 2'd0;
    localparam logic [1:0] MODE_1021  = 2'd1;
    localparam logic [1:0] MODE_8005  = 2'd2;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // MSB-first single-byte steps; reflected variants come from revin/revout around them.
    function automatic logic [7:0] crc8_07(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] b,
                                               input logic [15:0] poly);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ poly) : (r << 1);
        return r;
    endfunction

    function automatic logic [31:0] crc32_04c11db7(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {b, 24'h000000};
        for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        return r;
    endfunction

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   gnt_q, pick;
    logic [1:0]            mode_q, size_q, cnt_q, nlast_q;
    logic                  revin_q, revout_q, last_q, any_valid;
    logic [31:0]           xorv_q, crc_q, crc_d, word_q;
    logic [5:0]            cfg_sel;
    logic [31:0]           init_sel, xorv_sel, data_sel, word_sh;
    logic [7:0]            byte_in;
    logic [31:0]           out_v, out_mask;

    assign any_valid = |req_valid_i;
    assign cfg_sel   = req_cfg_i[int'(pick)*6 +: 6];
    assign init_sel  = req_init_i[int'(pick)*32 +: 32];
    assign xorv_sel  = req_xorv_i[int'(pick)*32 +: 32];
    assign data_sel  = req_data_i[int'(gnt_q)*32 +: 32];

`ifdef CRC_SCHED_FIXPRIO_EN
    always_comb begin
        pick = '0;
        for (int k = REQ_NUM-1; k >= 0; k--) begin
            if (req_valid_i[k]) pick = ID_WIDTH'(k);
        end
    end
`else
    logic [ID_WIDTH-1:0] rr_q;
    logic                found;
    int                  idx;

    // Search starts just after the last served requester so every requester gets a turn.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            idx = (int'(rr_q) + k) % REQ_NUM;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                pick  = ID_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                             rr_q <= ID_WIDTH'(REQ_NUM-1);
        else if (state_q == RESP && res_ready_i)  rr_q <= gnt_q;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid)            state_d = FETCH;
            FETCH:   if (req_valid_i[gnt_q])   state_d = CALC;
            CALC:    if (cnt_q == nlast_q)     state_d = last_q ? RESP : FETCH;
            RESP:    if (res_ready_i)          state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_comb begin
        word_sh = word_q << {cnt_q, 3'b000};
        byte_in = revin_q ? rev8(word_sh[31:24]) : word_sh[31:24];
        crc_d   = crc_q;
        case (mode_q)
            MODE_CRC8: crc_d = {crc_q[31:8], crc8_07(crc_q[7:0], byte_in)};
            MODE_1021: crc_d = {crc_q[31:16], crc16_step(crc_q[15:0], byte_in, 16'h1021)};
            MODE_8005: crc_d = {crc_q[31:16], crc16_step(crc_q[15:0], byte_in, 16'h8005)};
            default:   crc_d = crc32_04c11db7(crc_q, byte_in);
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            mode_q   <= '0;
            size_q   <= '0;
            revin_q  <= 1'b0;
            revout_q <= 1'b0;
            xorv_q   <= '0;
            crc_q    <= '0;
            word_q   <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            nlast_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (any_valid) begin
                    gnt_q    <= pick;
                    size_q   <= cfg_sel[5:4];
                    revout_q <= cfg_sel[3];
                    revin_q  <= cfg_sel[2];
                    mode_q   <= cfg_sel[1:0];
                    xorv_q   <= xorv_sel;
                    crc_q    <= init_sel;
                end
                FETCH: if (req_valid_i[gnt_q]) begin
                    word_q  <= data_sel;
                    last_q  <= req_last_i[gnt_q];
                    nlast_q <= req_last_i[gnt_q] ? size_q : 2'd3;
                    cnt_q   <= '0;
                end
                CALC: begin
                    crc_q <= crc_d;
                    cnt_q <= cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (mode_q)
            MODE_CRC8: begin
                out_v    = {24'h0, revout_q ? rev8(crc_q[7:0]) : crc_q[7:0]};
                out_mask = 32'h0000_00FF;
            end
            MODE_1021, MODE_8005: begin
                out_v    = {16'h0, revout_q ? rev16(crc_q[15:0]) : crc_q[15:0]};
                out_mask = 32'h0000_FFFF;
            end
            default: begin
                out_v    = revout_q ? rev32(crc_q) : crc_q;
                out_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign busy_o      = (state_q != IDLE);
    assign res_valid_o = (state_q == RESP);
    assign res_data_o  = (state_q == RESP) ? ((out_v ^ xorv_q) & out_mask) : 32'h0;
    assign res_id_o    = (state_q == RESP) ? gnt_q : '0;
    assign req_ready_o = (state_q == FETCH) ? ({{(REQ_NUM-1){1'b0}}, 1'b1} << gnt_q) : '0;

endmodule

// File: tb/tb_crc_sched.sv
// Directed self-checking bench for crc_sched: known check vectors, arbitration order, stall and reset abort.
module tb_crc_sched;

    localparam int REQ_NUM = 4;
    localparam int IDW     = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_n_i;
    logic [REQ_NUM-1:0]   reqValid;
    logic [REQ_NUM-1:0]   req_ready_o;
    logic [REQ_NUM*32-1:0] req_data;
    logic [REQ_NUM-1:0]   req_last;
    logic [REQ_NUM*6-1:0] req_cfg;
    logic [REQ_NUM*32-1:0] req_init;
    logic [REQ_NUM*32-1:0] req_xorv;
    logic                 res_valid_o;
    logic                 resReady;
    logic [31:0]          res_data_o;
    logic [IDW-1:0]       res_id_o;
    logic                 busy_o;

    logic [31:0] wmem  [REQ_NUM][4];
    int          nw    [REQ_NUM];
    int          ptr   [REQ_NUM];
    bit          rep   [REQ_NUM];
    logic [5:0]  cfgR  [REQ_NUM];
    logic [31:0] initR [REQ_NUM];
    logic [31:0] xorvR [REQ_NUM];
    logic [REQ_NUM-1:0] hs;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    crc_sched #(.REQ_NUM(REQ_NUM)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_valid_i (reqValid),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_cfg_i   (req_cfg),
        .req_init_i  (req_init),
        .req_xorv_i  (req_xorv),
        .res_valid_o (res_valid_o),
        .res_ready_i (resReady),
        .res_data_o  (res_data_o),
        .res_id_o    (res_id_o),
        .busy_o      (busy_o)
    );

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            req_data[i*32 +: 32] = wmem[i][ptr[i]];
            req_last[i]          = (ptr[i] == nw[i] - 1);
            req_cfg[i*6 +: 6]    = cfgR[i];
            req_init[i*32 +: 32] = initR[i];
            req_xorv[i*32 +: 32] = xorvR[i];
        end
    end

    // Requester model: step to the next word after each accepted handshake.
    always begin
        @(negedge clk_i);
        hs = reqValid & req_ready_o;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (hs[i]) begin
                if (ptr[i] < nw[i] - 1) ptr[i] = ptr[i] + 1;
                else if (rep[i])        ptr[i] = 0;
                else                    reqValid[i] = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst_n_i  = 1'b0;
        reqValid = '0;
        resReady = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) rep[i] = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic load_frame(input int r, input int n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [5:0] cfg, input logic [31:0] init,
                              input logic [31:0] xorv, input bit repeatFrame);
        wmem[r][0] = w0;
        wmem[r][1] = w1;
        wmem[r][2] = w2;
        wmem[r][3] = 32'h0;
        nw[r]      = n;
        ptr[r]     = 0;
        rep[r]     = repeatFrame;
        cfgR[r]    = cfg;
        initR[r]   = init;
        xorvR[r]   = xorv;
        reqValid[r] = 1'b1;
    endtask

    task automatic wait_result(input bit ack, output logic [31:0] d, output logic [IDW-1:0] id,
                               output int cyc, output bit timedOut);
        cyc      = 0;
        timedOut = 1'b1;
        d        = '0;
        id       = '0;
        while (cyc < 400) begin
            @(posedge clk_i);
            cyc++;
            @(negedge clk_i);
            if (res_valid_o) begin
                timedOut = 1'b0;
                d        = res_data_o;
                id       = res_id_o;
                break;
            end
        end
        if (!timedOut && ack) begin
            resReady = 1'b1;
            @(posedge clk_i);
            #1;
            resReady = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_ready_o !== 4'h0) begin errors++; $display("[TB] FAIL rst_ready: got %h expected 0", req_ready_o); end
        checks++; if (res_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", res_valid_o); end
        checks++; if (res_data_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_data: got %h expected 0", res_data_o); end
        checks++; if (res_id_o !== 2'd0) begin errors++; $display("[TB] FAIL rst_id: got %0d expected 0", res_id_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_crc32();
        logic [31:0] d; logic [IDW-1:0] id; int cyc; bit to;
        do_reset();
        @(posedge clk_i); #1;
        load_frame(0, 3, 32'h31323334, 32'h35363738, 32'h39AABBCC, 6'h0F, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_result(1'b1, d, id, cyc, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL crc32_timeout: got no result expected a result"); end
        checks++; if (d !== 32'hCBF43926) begin errors++; $display("[TB] FAIL crc32_data: got %h expected cbf43926", d); end
        checks++; if (id !== 2'd0) begin errors++; $display("[TB] FAIL crc32_id: got %0d expected 0", id); end
        checks++; if (cyc != 13) begin errors++; $display("[TB] FAIL crc32_latency: got %0d expected 13", cyc); end
    endtask

    task automatic test_crc16_1021();
        logic [31:0] d; logic [IDW-1:0] id; int cyc; bit to;
        @(posedge clk_i); #1;
        load_frame(1, 3, 32'h31323334, 32'h35363738, 32'h39FFFFFF, 6'h01, 32'h0000FFFF, 32'h0, 1'b0);
        wait_result(1'b1, d, id, cyc, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL c1021_timeout: got no result expected a result"); end
        checks++; if (d !== 32'h000029B1) begin errors++; $display("[TB] FAIL c1021_data: got %h expected 000029b1", d); end
        checks++; if (id !== 2'd1) begin errors++; $display("[TB] FAIL c1021_id: got %0d expected 1", id); end
    endtask

    task automatic test_crc8_8005();
        logic [31:0] d; logic [IDW-1:0] id; int cyc; bit to;
        @(posedge clk_i); #1;
        load_frame(2, 3, 32'h31323334, 32'h35363738, 32'h39000000, 6'h00, 32'h0, 32'h0, 1'b0);
        wait_result(1'b1, d, id, cyc, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL crc8_timeout: got no result expected a result"); end
        checks++; if (d !== 32'h000000F4) begin errors++; $display("[TB] FAIL crc8_data: got %h expected 000000f4", d); end
        checks++; if (id !== 2'd2) begin errors++; $display("[TB] FAIL crc8_id: got %0d expected 2", id); end
        @(posedge clk_i); #1;
        load_frame(2, 3, 32'h31323334, 32'h35363738, 32'h39000000, 6'h0E, 32'h0, 32'h0, 1'b0);
        wait_result(1'b1, d, id, cyc, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL c8005_timeout: got no result expected a result"); end
        checks++; if (d !== 32'h0000BB3D) begin errors++; $display("[TB] FAIL c8005_data: got %h expected 0000bb3d", d); end
        checks++; if (id !== 2'd2) begin errors++; $display("[TB] FAIL c8005_id: got %0d expected 2", id); end
    endtask

    task automatic test_round_robin();
        logic [31:0] d; logic [IDW-1:0] id; int cyc; bit to;
        int expId [5] = '{0, 1, 2, 3, 0};
        do_reset();
        @(posedge clk_i); #1;
        for (int r = 0; r < REQ_NUM; r++)
            load_frame(r, 1, 32'h0, 32'h0, 32'h0, 6'h33, 32'h0, 32'hA5000000 + r, 1'b1);
        for (int n = 0; n < 5; n++) begin
            wait_result(n != 1, d, id, cyc, to);
            checks++; if (to) begin errors++; $display("[TB] FAIL rr_timeout%0d: got no result expected a result", n); end
            checks++; if (id !== IDW'(expId[n])) begin errors++; $display("[TB] FAIL rr_id%0d: got %0d expected %0d", n, id, expId[n]); end
            checks++; if (d !== 32'hA5000000 + expId[n]) begin errors++; $display("[TB] FAIL rr_data%0d: got %h expected %h", n, d, 32'hA5000000 + expId[n]); end
            if (n == 1 && !to) begin
                repeat (5) begin
                    @(posedge clk_i);
                    @(negedge clk_i);
                    checks++;
                    if (res_valid_o !== 1'b1 || res_id_o !== 2'd1 || res_data_o !== 32'hA5000001) begin
                        errors++;
                        $display("[TB] FAIL rr_stall: got v=%b id=%0d d=%h expected v=1 id=1 d=a5000001", res_valid_o, res_id_o, res_data_o);
                    end
                end
                resReady = 1'b1;
                @(posedge clk_i); #1;
                resReady = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d; logic [IDW-1:0] id; int cyc; bit to; bit sawValid;
        do_reset();
        @(posedge clk_i); #1;
        load_frame(0, 3, 32'h31323334, 32'h35363738, 32'h39000000, 6'h0F, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        repeat (8) @(posedge clk_i);
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 1", busy_o); end
        rst_n_i = 1'b0;
        #1;
        checks++; if (req_ready_o !== 4'h0) begin errors++; $display("[TB] FAIL mid_ready: got %h expected 0", req_ready_o); end
        checks++; if (res_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0", res_valid_o); end
        checks++; if (res_data_o !== 32'h0) begin errors++; $display("[TB] FAIL mid_data: got %h expected 0", res_data_o); end
        checks++; if (res_id_o !== 2'd0) begin errors++; $display("[TB] FAIL mid_id: got %0d expected 0", res_id_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy_rst: got %b expected 0", busy_o); end
        reqValid = '0;
        sawValid = 1'b0;
        repeat (3) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (res_valid_o) sawValid = 1'b1;
        end
        rst_n_i = 1'b1;
        repeat (3) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (res_valid_o) sawValid = 1'b1;
        end
        checks++; if (sawValid) begin errors++; $display("[TB] FAIL mid_no_result: got res_valid expected none"); end
        @(posedge clk_i); #1;
        load_frame(0, 3, 32'h31323334, 32'h35363738, 32'h39000000, 6'h0F, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_result(1'b1, d, id, cyc, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL mid_timeout: got no result expected a result"); end
        checks++; if (d !== 32'hCBF43926) begin errors++; $display("[TB] FAIL mid_data_resend: got %h expected cbf43926", d); end
        checks++; if (id !== 2'd0) begin errors++; $display("[TB] FAIL mid_id_resend: got %0d expected 0", id); end
    endtask

    task automatic test_priority();
        logic [31:0] d; logic [IDW-1:0] id; int cyc; bit to;
`ifdef CRC_SCHED_FIXPRIO_EN
        int expId [3] = '{0, 0, 0};
`else
        int expId [3] = '{0, 3, 0};
`endif
        do_reset();
        @(posedge clk_i); #1;
        load_frame(0, 1, 32'h0, 32'h0, 32'h0, 6'h33, 32'h0, 32'hA5000000, 1'b1);
        load_frame(3, 1, 32'h0, 32'h0, 32'h0, 6'h33, 32'h0, 32'hA5000003, 1'b1);
        for (int n = 0; n < 3; n++) begin
            wait_result(1'b1, d, id, cyc, to);
            checks++; if (to) begin errors++; $display("[TB] FAIL prio_timeout%0d: got no result expected a result", n); end
            checks++; if (id !== IDW'(expId[n])) begin errors++; $display("[TB] FAIL prio_id%0d: got %0d expected %0d", n, id, expId[n]); end
            checks++; if (d !== 32'hA5000000 + expId[n]) begin errors++; $display("[TB] FAIL prio_data%0d: got %h expected %h", n, d, 32'hA5000000 + expId[n]); end
        end
    endtask

    initial begin
        rst_n_i  = 1'b0;
        reqValid = '0;
        resReady = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            nw[i] = 1; ptr[i] = 0; rep[i] = 1'b0;
            cfgR[i] = '0; initR[i] = '0; xorvR[i] = '0;
            for (int j = 0; j < 4; j++) wmem[i][j] = '0;
        end
        test_reset();
        test_crc32();
        test_crc16_1021();
        test_crc8_8005();
        test_round_robin();
        test_reset_midframe();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
